// File: rtl/usb_ulpi_tx_state_machine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_ulpi_tx_state_machine : link-side ULPI transmit controller
// (TX CMD, nxt-paced payload, stp).
// Rev 1.0
// ----------------------------------------------------------------------------
module usb_ulpi_tx_state_machine #(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_pid_only,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_abort,
  input  logic       dir,
  input  logic       nxt,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       stp
);

  localparam int CNT_W = $clog2(NXT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(NXT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_CMD   = 3'd1,
    TX_DATA  = 3'd2,
    STOP     = 3'd3,
    ERR_STOP = 3'd4,
    WAIT_DIR = 3'd5
  } state_t;

  state_t           state;
  logic             pid_only_q;
  logic             last_q;
  logic [CNT_W-1:0] nxt_cnt;
  logic             pop;

  // A dir takeover suppresses the pop even when nxt and valid are high.
  always_comb begin
    pop = 1'b0;
    if (!dir && nxt && tx_data_valid) begin
      if (state == TX_CMD)
        pop = !pid_only_q;
      else if (state == TX_DATA)
        pop = !last_q;
    end
  end

  assign tx_data_ready = pop;
  assign tx_busy       = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      pid_only_q    <= 1'b0;
      last_q        <= 1'b0;
      nxt_cnt       <= '0;
      ulpi_data_out <= 8'h00;
      ulpi_data_oe  <= 1'b0;
      stp           <= 1'b0;
      tx_done       <= 1'b0;
      tx_abort      <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start && !dir) begin
            pid_only_q    <= tx_pid_only;
            ulpi_data_out <= {4'h4, tx_pid};
            ulpi_data_oe  <= 1'b1;
            nxt_cnt       <= '0;
            state         <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (dir) begin
            ulpi_data_out <= 8'h00;
            ulpi_data_oe  <= 1'b0;
            stp           <= 1'b0;
            tx_abort      <= 1'b1;
            state         <= WAIT_DIR;
          end else if (nxt) begin
            if (pid_only_q) begin
              ulpi_data_out <= 8'h00;
              stp           <= 1'b1;
              tx_done       <= 1'b1;
              state         <= STOP;
            end else if (tx_data_valid) begin
              ulpi_data_out <= tx_data;
              last_q        <= tx_last;
              state         <= TX_DATA;
            end else begin
              ulpi_data_out <= 8'hFF;
              stp           <= 1'b1;
              tx_abort      <= 1'b1;
              state         <= ERR_STOP;
            end
          end else if (nxt_cnt == TIMEOUT_VAL) begin
            ulpi_data_out <= 8'hFF;
            stp           <= 1'b1;
            tx_abort      <= 1'b1;
            state         <= ERR_STOP;
          end else begin
            nxt_cnt <= nxt_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (dir) begin
            ulpi_data_out <= 8'h00;
            ulpi_data_oe  <= 1'b0;
            stp           <= 1'b0;
            tx_abort      <= 1'b1;
            state         <= WAIT_DIR;
          end else if (nxt) begin
            if (last_q) begin
              ulpi_data_out <= 8'h00;
              stp           <= 1'b1;
              tx_done       <= 1'b1;
              state         <= STOP;
            end else if (tx_data_valid) begin
              ulpi_data_out <= tx_data;
              last_q        <= tx_last;
            end else begin
              ulpi_data_out <= 8'hFF;
              stp           <= 1'b1;
              tx_abort      <= 1'b1;
              state         <= ERR_STOP;
            end
          end
        end
        STOP, ERR_STOP: begin
          // dir is deliberately ignored here so the stop cycle always completes.
          ulpi_data_out <= 8'h00;
          ulpi_data_oe  <= 1'b0;
          stp           <= 1'b0;
          state         <= IDLE;
        end
        WAIT_DIR: begin
          if (!dir)
            state <= IDLE;
        end
        default: begin
          ulpi_data_out <= 8'h00;
          ulpi_data_oe  <= 1'b0;
          stp           <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
